pacman_motion: RTL and testbench

PACMAN_MOTION -- requirements
Module: pacman_motion

---
 rtl/pacman_motion.sv | 214 +++++++++++++++++++++
 tb/tb_pacman_motion.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pacman_motion.sv
// Pac-Man movement engine: per-frame wall-checked motion with queued turns,
// instant reversal, tunnel wrap and mouth animation.
module pacman_motion #(
    parameter int START_X  = 119,
    parameter int START_Y  = 228,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 239,
    parameter int CX_OFS   = 7,
    parameter int CY_OFS   = 4,
    parameter int ANIM_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       enable,
    input  logic       respawn,
    input  logic       joy_valid,
    input  logic [1:0] joy_dir,
    output logic       wall_req,
    output logic [9:0] wall_qx,
    output logic [9:0] wall_qy,
    input  logic       wall_ack,
    input  logic       wall_blocked,
    output logic [9:0] pacman_xloc,
    output logic [9:0] pacman_yloc,
    output logic [1:0] pacman_dir,
    output logic [1:0] pacman_animation,
    output logic       moving,
    output logic       overrun
);

    localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    typedef enum logic [1:0] {S_WAIT, S_QTURN, S_QFWD, S_UPDATE} state_t;

    state_t          r_state, w_state_nxt;
    logic [9:0]      r_xloc, r_yloc, r_qx, r_qy;
    logic [1:0]      r_dir, r_pend, r_turn_dir, r_anim;
    logic            r_pend_v, r_wall_req, r_moving, r_overrun;
    logic [CW-1:0]   r_anim_cnt;

    logic            w_aligned, w_reverse, w_turn, w_go, w_ack;
    logic            w_issue, w_set_dir, w_clr_pend, w_step, w_stall;
    logic [1:0]      w_issue_dir, w_new_dir;
    logic [9:0]      w_tx, w_ty, w_mx, w_my;

    assign w_aligned = (r_xloc[2:0] == 3'(CX_OFS)) && (r_yloc[2:0] == 3'(CY_OFS));
    assign w_reverse = r_pend_v && (r_pend == (r_dir ^ 2'b10));
    assign w_turn    = w_aligned && r_pend_v && (r_pend != r_dir) && !w_reverse;
    assign w_go      = (r_state == S_WAIT) && frame_tick && enable;
    assign w_ack     = wall_ack && r_wall_req;

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_issue_dir = r_dir;
        w_set_dir   = 1'b0;
        w_new_dir   = r_dir;
        w_clr_pend  = 1'b0;
        w_step      = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            S_WAIT: begin
                if (w_go) begin
                    if (w_reverse) begin
                        w_set_dir  = 1'b1;
                        w_new_dir  = r_pend;
                        w_clr_pend = 1'b1;
                    end
                    if (w_turn) begin
                        w_state_nxt = S_QTURN;
                        w_issue     = 1'b1;
                        w_issue_dir = r_pend;
                    end else if (w_aligned) begin
                        w_state_nxt = S_QFWD;
                        w_issue     = 1'b1;
                        w_issue_dir = w_reverse ? r_pend : r_dir;
                    end else begin
                        w_state_nxt = S_UPDATE;
                    end
                end
            end
            S_QTURN: begin
                if (w_ack) begin
                    w_state_nxt = S_QFWD;
                    if (!wall_blocked) begin
                        w_set_dir  = 1'b1;
                        w_new_dir  = r_turn_dir;
                        // a newer joystick request made mid-query stays pending
                        w_clr_pend = (r_pend == r_turn_dir);
                    end
                end
            end
            S_QFWD: begin
                // arriving from QTURN the request dropped for a cycle; reissue
                if (!r_wall_req) begin
                    w_issue     = 1'b1;
                    w_issue_dir = r_dir;
                end else if (w_ack) begin
                    if (wall_blocked) begin
                        w_stall     = 1'b1;
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_state_nxt = S_UPDATE;
                    end
                end
            end
            S_UPDATE: begin
                w_step      = 1'b1;
                w_state_nxt = S_WAIT;
            end
            default: w_state_nxt = S_WAIT;
        endcase
    end

    always_comb begin
        w_tx = r_xloc;
        w_ty = r_yloc;
        case (w_issue_dir)
            2'd0: w_tx = r_xloc + 10'd8;
            2'd1: w_ty = r_yloc + 10'd8;
            2'd2: w_tx = r_xloc - 10'd8;
            default: w_ty = r_yloc - 10'd8;
        endcase
    end

    // one-pixel step with horizontal tunnel wrap
    always_comb begin
        w_mx = r_xloc;
        w_my = r_yloc;
        case (r_dir)
            2'd0: w_mx = (r_xloc == 10'(X_MAX)) ? 10'(X_MIN) : r_xloc + 10'd1;
            2'd1: w_my = r_yloc + 10'd1;
            2'd2: w_mx = (r_xloc == 10'(X_MIN)) ? 10'(X_MAX) : r_xloc - 10'd1;
            default: w_my = r_yloc - 10'd1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_WAIT;
            r_xloc     <= 10'(START_X);
            r_yloc     <= 10'(START_Y);
            r_dir      <= 2'd0;
            r_pend     <= 2'd0;
            r_pend_v   <= 1'b0;
            r_turn_dir <= 2'd0;
            r_anim     <= 2'd0;
            r_anim_cnt <= '0;
            r_moving   <= 1'b0;
            r_wall_req <= 1'b0;
            r_qx       <= 10'd0;
            r_qy       <= 10'd0;
            r_overrun  <= 1'b0;
        end else begin
            if (frame_tick && (r_state != S_WAIT))
                r_overrun <= 1'b1;
            if (respawn) begin
                r_state    <= S_WAIT;
                r_xloc     <= 10'(START_X);
                r_yloc     <= 10'(START_Y);
                r_dir      <= 2'd0;
                r_pend_v   <= 1'b0;
                r_anim     <= 2'd0;
                r_anim_cnt <= '0;
                r_moving   <= 1'b0;
                r_wall_req <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                if (r_state == S_WAIT)
                    r_turn_dir <= r_pend;
                if (joy_valid) begin
                    r_pend   <= joy_dir;
                    r_pend_v <= 1'b1;
                end else if (w_clr_pend) begin
                    r_pend_v <= 1'b0;
                end
                if (w_set_dir)
                    r_dir <= w_new_dir;
                if (w_issue) begin
                    r_wall_req <= 1'b1;
                    r_qx       <= w_tx;
                    r_qy       <= w_ty;
                end else if (w_ack) begin
                    r_wall_req <= 1'b0;
                end
                if (w_step) begin
                    r_xloc   <= w_mx;
                    r_yloc   <= w_my;
                    r_moving <= 1'b1;
                    if (r_anim_cnt == CW'(ANIM_DIV - 1)) begin
                        r_anim_cnt <= '0;
                        r_anim     <= r_anim + 2'd1;
                    end else begin
                        r_anim_cnt <= r_anim_cnt + 1'b1;
                    end
                end
                if (w_stall)
                    r_moving <= 1'b0;
            end
        end
    end

    assign wall_req         = r_wall_req;
    assign wall_qx          = r_qx;
    assign wall_qy          = r_qy;
    assign pacman_xloc      = r_xloc;
    assign pacman_yloc      = r_yloc;
    assign pacman_dir       = r_dir;
    assign pacman_animation = r_anim;
    assign moving           = r_moving;
    assign overrun          = r_overrun;

endmodule

// File: tb/tb_pacman_motion.sv
// Bench for pacman_motion: directed scenarios plus random play against a
// frame-level reference model with a behavioural wall map.
module tb_pacman_motion;

    logic       clk = 1'b0, rst = 1'b1;
    logic       frame_tick = 0, enable = 1, respawn = 0, joy_valid = 0;
    logic [1:0] joy_dir = 0;
    logic       wall_req, wall_ack = 0, wall_blocked = 0;
    logic [9:0] wall_qx, wall_qy, pacman_xloc, pacman_yloc;
    logic [1:0] pacman_dir, pacman_animation;
    logic       moving, overrun;

    pacman_motion dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .enable(enable),
        .respawn(respawn), .joy_valid(joy_valid), .joy_dir(joy_dir),
        .wall_req(wall_req), .wall_qx(wall_qx), .wall_qy(wall_qy),
        .wall_ack(wall_ack), .wall_blocked(wall_blocked),
        .pacman_xloc(pacman_xloc), .pacman_yloc(pacman_yloc),
        .pacman_dir(pacman_dir), .pacman_animation(pacman_animation),
        .moving(moving), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int wall_mode = 0;
    bit ack_hold = 0;
    int dly = 0;
    logic [19:0] obs_q[$];
    logic [19:0] exp_q[$];

    // reference state
    int mx, my, mdir, mpend, nmoves;
    bit mpv, mmov;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic bit wall_at(input int x, input int y);
        case (wall_mode)
            1: return (((x / 8) * 5 + (y / 8) * 3) % 7) == 0;
            2: return (x == 119) && (y == 220);
            3: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // wall responder: acks a pending request after a random 0..2 cycle delay
    initial begin
        forever begin
            @(negedge clk);
            wall_ack = 0;
            wall_blocked = 0;
            if (wall_req && !ack_hold) begin
                if (dly == 0) begin
                    wall_ack = 1;
                    wall_blocked = wall_at(int'(wall_qx), int'(wall_qy));
                    obs_q.push_back({wall_qx, wall_qy});
                    dly = $urandom_range(0, 2);
                end else begin
                    dly--;
                end
            end
        end
    end

    task automatic model_reset();
        mx = 119; my = 228; mdir = 0; mpend = 0; mpv = 0; nmoves = 0; mmov = 0;
    endtask

    task automatic ahead(input int d, output int tx, output int ty);
        tx = mx; ty = my;
        case (d)
            0: tx = (mx + 8) % 1024;
            1: ty = (my + 8) % 1024;
            2: tx = (mx + 1024 - 8) % 1024;
            default: ty = (my + 1024 - 8) % 1024;
        endcase
    endtask

    task automatic model_frame(input bit joy_now, input int jd);
        int tx, ty;
        bit aligned, go;
        aligned = (mx % 8 == 7) && (my % 8 == 4);
        if (mpv && mpend == (mdir + 2) % 4) begin
            mdir = mpend; mpv = 0;
        end else if (aligned && mpv && mpend != mdir) begin
            ahead(mpend, tx, ty);
            exp_q.push_back({tx[9:0], ty[9:0]});
            if (!wall_at(tx, ty)) begin mdir = mpend; mpv = 0; end
        end
        if (joy_now) begin mpend = jd; mpv = 1; end
        go = 1;
        if (aligned) begin
            ahead(mdir, tx, ty);
            exp_q.push_back({tx[9:0], ty[9:0]});
            go = !wall_at(tx, ty);
        end
        if (go) begin
            case (mdir)
                0: mx = (mx == 239) ? 0 : mx + 1;
                1: my = (my + 1) % 1024;
                2: mx = (mx == 0) ? 239 : mx - 1;
                default: my = (my + 1023) % 1024;
            endcase
            nmoves++;
            mmov = 1;
        end else begin
            mmov = 0;
        end
    endtask

    task automatic compare(input string tag);
        check({tag, ".x"}, pacman_xloc, mx);
        check({tag, ".y"}, pacman_yloc, my);
        check({tag, ".dir"}, pacman_dir, mdir);
        check({tag, ".anim"}, pacman_animation, (nmoves / 4) % 4);
        check({tag, ".moving"}, moving, mmov);
        check({tag, ".idle"}, wall_req, 0);
        check({tag, ".nq"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check({tag, ".qxy"}, obs_q[i], exp_q[i]);
    endtask

    task automatic frame(input string tag, input bit en, input bit joy_now, input int jd);
        obs_q.delete(); exp_q.delete();
        @(negedge clk);
        frame_tick = 1; enable = en;
        if (joy_now) begin joy_valid = 1; joy_dir = 2'(jd); end
        @(negedge clk);
        frame_tick = 0; joy_valid = 0; enable = 1;
        repeat (14) @(negedge clk);
        if (en) model_frame(joy_now, jd);
        else if (joy_now) begin mpend = jd; mpv = 1; end
        compare(tag);
    endtask

    task automatic joy(input int d);
        @(negedge clk);
        joy_valid = 1; joy_dir = 2'(d);
        @(negedge clk);
        joy_valid = 0;
        mpend = d; mpv = 1;
    endtask

    task automatic do_respawn(input bit noisy);
        @(negedge clk);
        respawn = 1;
        if (noisy) begin frame_tick = 1; joy_valid = 1; joy_dir = 2'd3; end
        @(negedge clk);
        respawn = 0; frame_tick = 0; joy_valid = 0;
        model_reset();
        obs_q.delete();
    endtask

    initial begin
        int r;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        compare("reset");
        check("reset.overrun", overrun, 0);

        // straight motion
        for (int i = 0; i < 3; i++) frame("straight", 1, 0, 0);
        check("straight.x3", pacman_xloc, 122);

        // blocked turn, then the still-pending turn succeeds at next centre
        do_respawn(1);
        wall_mode = 2;
        joy(3);
        frame("bturn", 1, 0, 0);
        check("bturn.dir", pacman_dir, 0);
        for (int i = 0; i < 8; i++) frame("bturn2", 1, 0, 0);
        check("bturn.late", pacman_dir, 3);

        // off-centre reversal then run left through the tunnel
        do_respawn(0);
        wall_mode = 0;
        frame("rev0", 1, 0, 0);
        frame("rev0", 1, 0, 0);
        joy(2);
        frame("rev", 1, 0, 0);
        check("rev.x", pacman_xloc, 120);
        for (int i = 0; i < 121; i++) frame("tunnel", 1, 0, 0);
        check("tunnel.x", pacman_xloc, 239);

        // joystick coincident with reversal: new request survives
        do_respawn(0);
        frame("coin0", 1, 0, 0);
        joy(2);
        frame("coin", 1, 1, 1);
        frame("coin2", 1, 0, 0);
        check("coin.dir", pacman_dir, 1);

        // respawn mid-query and overrun
        do_respawn(0);
        ack_hold = 1;
        @(negedge clk); frame_tick = 1;
        @(negedge clk); frame_tick = 0;
        repeat (2) @(negedge clk);
        check("midq.req", wall_req, 1);
        check("midq.ovr0", overrun, 0);
        @(negedge clk); frame_tick = 1;
        @(negedge clk); frame_tick = 0;
        check("midq.ovr", overrun, 1);
        @(negedge clk); respawn = 1;
        @(negedge clk); respawn = 0;
        check("midq.req0", wall_req, 0);
        check("midq.x", pacman_xloc, 119);
        check("midq.y", pacman_yloc, 228);
        ack_hold = 0;
        model_reset();
        frame("midq.after", 1, 0, 0);

        // stall freezes animation and clears moving
        do_respawn(0);
        for (int i = 0; i < 5; i++) frame("stall0", 1, 0, 0);
        wall_mode = 3;
        for (int i = 0; i < 5; i++) frame("stall", 1, 0, 0);
        check("stall.moving", moving, 0);
        check("stall.anim", pacman_animation, 2);

        // random play
        do_respawn(0);
        wall_mode = 1;
        for (int it = 0; it < 250; it++) begin
            r = $urandom_range(0, 99);
            if (r < 25) joy($urandom_range(0, 3));
            else if (r < 33) frame("rnd.off", 0, $urandom_range(0, 1), $urandom_range(0, 3));
            else if (r < 36) do_respawn($urandom_range(0, 1));
            else frame("rnd", 1, 0, 0);
        end

        check("end.ovr", overrun, 1);
        @(negedge clk); rst = 1;
        @(negedge clk);
        check("rst.ovr", overrun, 0);
        check("rst.x", pacman_xloc, 119);
        check("rst.req", wall_req, 0);
        rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
